// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the 4-digit 7-segment scan controller.
//   NUM_DIGITS    : number of multiplexed digits
//   scan_state_t  : per-slot phase (blank / on / off)
//   SEG_CODE_*    : active-high {g,f,e,d,c,b,a} glyphs for 0..F
//   SEG_OFF       : active-high all-dark segment word (dp included)
//   DIG_OFF       : active-high no-digit-selected strobe word
//   seg_code()    : nibble -> glyph lookup
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;
  localparam logic [6:0] SEG_CODE_A = 7'h77;
  localparam logic [6:0] SEG_CODE_B = 7'h7C;
  localparam logic [6:0] SEG_CODE_C = 7'h39;
  localparam logic [6:0] SEG_CODE_D = 7'h5E;
  localparam logic [6:0] SEG_CODE_E = 7'h79;
  localparam logic [6:0] SEG_CODE_F = 7'h71;

  localparam logic [7:0]            SEG_OFF = 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = '0;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = SEG_CODE_0;
      4'h1:    code = SEG_CODE_1;
      4'h2:    code = SEG_CODE_2;
      4'h3:    code = SEG_CODE_3;
      4'h4:    code = SEG_CODE_4;
      4'h5:    code = SEG_CODE_5;
      4'h6:    code = SEG_CODE_6;
      4'h7:    code = SEG_CODE_7;
      4'h8:    code = SEG_CODE_8;
      4'h9:    code = SEG_CODE_9;
      4'hA:    code = SEG_CODE_A;
      4'hB:    code = SEG_CODE_B;
      4'hC:    code = SEG_CODE_C;
      4'hD:    code = SEG_CODE_D;
      4'hE:    code = SEG_CODE_E;
      default: code = SEG_CODE_F;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// seg7_hex_decode
// ----------------------------------------------------------------------------
// Combinational hex-digit decoder producing an active-high segment word.
// Ports:
//   nibble : 4-bit hex value to display
//   dp     : decimal point request
//   code   : {dp,g,f,e,d,c,b,a}, 1 = segment lit
// Revision: 1.0 - initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] code
);

  always_comb begin
    code = {dp, seg_code(nibble)};
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller for a 4-digit 7-segment display with
// per-slot blanking, PWM brightness and tear-free frame commit.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   frame_valid  : producer offers a frame on frame_*
//   frame_ready  : controller can accept a frame (pending buffer empty)
//   frame_data   : digit nibbles, [15:12] = digit 0 (leftmost)
//   frame_dp     : decimal points, bit 3 = digit 0
//   frame_blank  : force digit dark, bit 3 = digit 0
//   brightness   : 0 = dimmest .. 7 = full, sampled at slot start
//   seg          : {dp,g..a} of the selected digit (polarity per parameter)
//   seg_dig      : one-hot digit strobe, bit 3 = digit 0
//   frame_sync   : one-cycle pulse when a pending frame is committed
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV_SLOT       = 12500,
  parameter int BLANK_CYC      = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [15:0]           frame_data,
  input  logic [NUM_DIGITS-1:0] frame_dp,
  input  logic [NUM_DIGITS-1:0] frame_blank,
  input  logic [2:0]            brightness,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] seg_dig,
  output logic                  frame_sync
);

  localparam int CNT_W = (DIV_SLOT > 1) ? $clog2(DIV_SLOT) : 1;
  // Wide enough for the (window * 8) product before the divide-by-8.
  localparam int LEN_W = $clog2(DIV_SLOT * 8 + 1);

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DIV_SLOT - 1);
  localparam logic [LEN_W-1:0]      BLANK_L = LEN_W'(BLANK_CYC);
  localparam logic [LEN_W-1:0]      WIN_L   = LEN_W'(DIV_SLOT - BLANK_CYC);
  localparam logic [7:0]            SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV = DIG_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]      cnt;
  logic [1:0]            idx;
  scan_state_t           state;
  logic [LEN_W-1:0]      on_len;
  logic                  live;
  logic                  pending_full;
  logic [15:0]           pend_data, act_data;
  logic [NUM_DIGITS-1:0] pend_dp, pend_blank, act_dp, act_blank;

  logic                  wrap, boundary, xfer, commit;
  logic [CNT_W-1:0]      cnt_next;
  logic [LEN_W-1:0]      len_now, eff_len, on_end, cnt_next_l;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0] dig_onehot;
  logic [7:0]            dec_code;

  assign wrap       = (cnt == CNT_MAX);
  assign cnt_next   = wrap ? '0 : cnt + CNT_W'(1);
  assign cnt_next_l = LEN_W'(cnt_next);
  assign boundary   = wrap && (idx == 2'd3);
  assign commit     = boundary && pending_full;
  assign frame_ready = live && !pending_full;
  assign xfer       = frame_valid && frame_ready;

  assign len_now = (WIN_L * (LEN_W'(brightness) + LEN_W'(1))) >> 3;
  // During cnt==0 the slot's on_len register is still being loaded, so the
  // live value is used for any decision made in that cycle.
  assign eff_len = (cnt == '0) ? len_now : on_len;
  assign on_end  = BLANK_L + eff_len;

  assign dig_onehot = NUM_DIGITS'(4'b1000 >> idx);

  always_comb begin
    cur_nib   = act_data[15:12];
    cur_dp    = act_dp[3];
    cur_blank = act_blank[3];
    case (idx)
      2'd1: begin cur_nib = act_data[11:8]; cur_dp = act_dp[2]; cur_blank = act_blank[2]; end
      2'd2: begin cur_nib = act_data[7:4];  cur_dp = act_dp[1]; cur_blank = act_blank[1]; end
      2'd3: begin cur_nib = act_data[3:0];  cur_dp = act_dp[0]; cur_blank = act_blank[0]; end
      default: ;
    endcase
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .code   (dec_code)
  );

  // Slot counter, digit index and per-slot phase. state always describes the
  // phase of the current cnt value, so transitions look at cnt_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 2'd0;
      state  <= S_BLANK;
      on_len <= '0;
    end else begin
      cnt <= cnt_next;
      if (cnt == '0) begin
        on_len <= len_now;
      end
      if (wrap) begin
        idx   <= idx + 2'd1;
        state <= (BLANK_CYC == 0) ? S_ON : S_BLANK;
      end else begin
        case (state)
          S_BLANK: if (cnt_next_l == BLANK_L) state <= S_ON;
          // At full brightness on_end equals DIV_SLOT and is never reached,
          // so the ON phase runs to the wrap.
          S_ON:    if (cnt_next_l == on_end)  state <= S_OFF;
          default: ;
        endcase
      end
    end
  end

  // Pending/active frame buffers. A commit only happens while pending is
  // full, which also holds frame_ready low, so commit and transfer never
  // coincide; a transfer on a boundary therefore waits for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      live         <= 1'b0;
      pending_full <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      act_data     <= '0;
      act_dp       <= '0;
      act_blank    <= '1;
    end else begin
      live <= 1'b1;
      if (commit) begin
        act_data     <= pend_data;
        act_dp       <= pend_dp;
        act_blank    <= pend_blank;
        pending_full <= 1'b0;
      end else if (xfer) begin
        pend_data    <= frame_data;
        pend_dp      <= frame_dp;
        pend_blank   <= frame_blank;
        pending_full <= 1'b1;
      end
    end
  end

  // Registered pin drivers with polarity folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF ^ SEG_INV;
      seg_dig    <= DIG_OFF ^ DIG_INV;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= commit;
      if ((state == S_ON) && !cur_blank) begin
        seg     <= dec_code ^ SEG_INV;
        seg_dig <= dig_onehot ^ DIG_INV;
      end else begin
        seg     <= SEG_OFF ^ SEG_INV;
        seg_dig <= DIG_OFF ^ DIG_INV;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for seg7_scan_ctrl with DIV_SLOT=16, BLANK_CYC=2 and
// active-low outputs. cyc counts clock edges since reset release; after edge
// n the DUT outputs reflect slot cycle (n-1)%16 of digit ((n-1)/16)%4, and
// frame boundaries fall on edges with n%64==0.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [15:0] frame_data = '0;
  logic [3:0]  frame_dp = '0;
  logic [3:0]  frame_blank = '0;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  seg;
  logic [3:0]  seg_dig;
  logic        frame_sync;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIV_SLOT       (16),
    .BLANK_CYC      (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_blank (frame_blank),
    .brightness  (brightness),
    .seg         (seg),
    .seg_dig     (seg_dig),
    .frame_sync  (frame_sync)
  );

  // segs: active-low pin values for digits 0..3, digit 0 in [31:24].
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [2:0]  bright;
    int          len;
    logic [31:0] segs;
  } vec_t;

  vec_t vecs [5];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_out(input int len, input logic [31:0] segs, input logic [3:0] blank);
    int         c, d;
    logic       dark, lit;
    logic [3:0] ed;
    logic [7:0] glyph, es;
    c     = (cyc - 1) % 16;
    d     = ((cyc - 1) / 16) % 4;
    dark  = blank[3 - d];
    lit   = (c >= 2) && (c < 2 + len) && !dark;
    ed    = lit ? ~(4'b1000 >> d) : 4'hF;
    glyph = segs[31 - 8*d -: 8];
    es    = lit ? glyph : 8'hFF;
    check("seg_dig", {28'd0, seg_dig}, {28'd0, ed});
    if (!dark) check("seg", {24'd0, seg}, {24'd0, es});
  endtask

  // Checks outputs up to and including the next boundary sample.
  task automatic scan_frame(input vec_t v);
    do begin
      tick;
      check_out(v.len, v.segs, v.blank);
      if (cyc % 64 != 0) check("no_sync_mid_frame", {31'd0, frame_sync}, 32'd0);
    end while (cyc % 64 != 0);
  endtask

  task automatic wait_sync(input string name);
    int k = 0;
    while (frame_sync !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    check(name, (frame_sync === 1'b1) ? (cyc % 64) : 999, 32'd0);
  endtask

  task automatic send(input vec_t v);
    int k = 0;
    frame_data  = v.data;
    frame_dp    = v.dp;
    frame_blank = v.blank;
    frame_valid = 1'b1;
    while (frame_ready !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    check("send_ready", {31'd0, frame_ready}, 32'd1);
    tick;
    frame_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_seg"},   {24'd0, seg},         32'hFF);
    check({name, "_dig"},   {28'd0, seg_dig},     32'hF);
    check({name, "_sync"},  {31'd0, frame_sync},  32'd0);
    check({name, "_ready"}, {31'd0, frame_ready}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tmp;
    int   slot;

    vecs[0] = '{16'h1A3C, 4'b0000, 4'b0000, 3'd7, 14, 32'hF988B0C6};
    vecs[1] = '{16'h0123, 4'b0000, 4'b0100, 3'd7, 14, 32'hC0F9A4B0};
    vecs[2] = '{16'h89EF, 4'b1010, 4'b0000, 3'd3,  7, 32'h0090068E};
    vecs[3] = '{16'h4567, 4'b0101, 4'b0000, 3'd0,  1, 32'h99128278};
    vecs[4] = '{16'hBD20, 4'b0000, 4'b0000, 3'd5, 10, 32'h83A1A4C0};

    // Reset and idle scanning with the blank power-up frame.
    rst = 1'b1;
    tick;
    tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc = 0;
    tick;
    check("ready_after_reset", {31'd0, frame_ready}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      tick;
      check("idle_dig", {28'd0, seg_dig}, 32'hF);
      check("idle_seg", {24'd0, seg}, 32'hFF);
      check("idle_sync", {31'd0, frame_sync}, 32'd0);
    end

    // Table: each frame is sent, committed at a boundary, then scanned.
    for (int r = 0; r < 5; r++) begin
      brightness = vecs[r].bright;
      send(vecs[r]);
      wait_sync("sync_phase");
      scan_frame(vecs[r]);
    end

    // Brightness change mid-slot only affects the following slot.
    brightness = 3'd3;
    while (cyc % 16 != 0) tick;
    while (cyc % 16 != 5) tick;
    brightness = 3'd0;
    slot = cyc / 16;
    for (int i = 0; i < 27; i++) begin
      tick;
      check_out((((cyc - 1) / 16) == slot) ? 7 : 1, vecs[4].segs, vecs[4].blank);
    end

    // Back-to-back frames: B waits for A to commit.
    brightness = 3'd7;
    while (cyc % 64 != 20) tick;
    send(vecs[0]);
    frame_data  = vecs[1].data;
    frame_dp    = vecs[1].dp;
    frame_blank = vecs[1].blank;
    frame_valid = 1'b1;
    while (cyc % 64 != 0) begin
      tick;
      if (cyc % 64 != 0) begin
        check("b2b_hold_ready", {31'd0, frame_ready}, 32'd0);
        check("b2b_no_early_sync", {31'd0, frame_sync}, 32'd0);
      end
    end
    check("b2b_sync_a", {31'd0, frame_sync}, 32'd1);
    check("b2b_ready_after_commit", {31'd0, frame_ready}, 32'd1);
    tick;
    frame_valid = 1'b0;
    check("b2b_b_accepted", {31'd0, frame_ready}, 32'd0);
    tmp = vecs[0];
    scan_frame(tmp);
    wait_sync("b2b_sync_b");
    scan_frame(vecs[1]);

    // Transfer landing exactly on a boundary commits one frame later.
    while (cyc % 64 != 63) tick;
    brightness  = vecs[3].bright;
    frame_data  = vecs[3].data;
    frame_dp    = vecs[3].dp;
    frame_blank = vecs[3].blank;
    frame_valid = 1'b1;
    tick;
    frame_valid = 1'b0;
    check("xfer_on_boundary_no_sync", {31'd0, frame_sync}, 32'd0);
    check("xfer_on_boundary_taken", {31'd0, frame_ready}, 32'd0);
    do begin
      tick;
      if (cyc % 64 != 0) check("xfer_on_boundary_wait", {31'd0, frame_sync}, 32'd0);
    end while (cyc % 64 != 0);
    wait_sync("xfer_on_boundary_sync");
    scan_frame(vecs[3]);

    // Reset mid-ON with a frame pending: pending is dropped, display blanks.
    brightness = 3'd7;
    send(vecs[0]);
    while (cyc % 16 != 0) tick;
    while (cyc % 16 != 6) tick;
    check("pre_reset_lit", {28'd0, seg_dig}, {28'd0, ~(4'b1000 >> (((cyc - 1) / 16) % 4))});
    rst = 1'b1;
    tick;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 140; i++) begin
      tick;
      check("post_reset_dig", {28'd0, seg_dig}, 32'hF);
      check("post_reset_sync", {31'd0, frame_sync}, 32'd0);
    end

    // Scanning must have restarted at digit 0, cnt 0.
    brightness = vecs[2].bright;
    send(vecs[2]);
    wait_sync("post_reset_sync_phase");
    scan_frame(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment debug display (PC[11:0] + ACC). It sequences digit strobes with a programmable slot period, inter-digit blanking (anti-ghosting) and PWM brightness. It accepts whole 4-digit frames from a producer through a valid/ready handshake and commits them only at frame boundaries, so the display never shows a torn PC/ACC value. It replaces the free-running digit mux between the CPU debug taps and the board pins.

Parameters:
DIV_SLOT, 12500, clocks per digit slot (≥ BLANK_CYC+8).
BLANK_CYC, 64, clocks at the start of each slot with all digits off.
SEG_ACTIVE_LOW, 1, when 1, segment outputs are inverted (0 = lit).
DIG_ACTIVE_LOW, 1, when 1, digit strobes are inverted (0 = selected).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_valid  in  1  producer has a frame on frame_*
frame_ready  out  1  controller can accept a frame
frame_data  in  16  digit nibbles; [15:12] = digit 0 (leftmost) … [3:0] = digit 3
frame_dp  in  4  decimal point per digit; bit 3 = digit 0
frame_blank  in  4  force digit dark; bit 3 = digit 0
brightness  in  3  0 = dimmest, 7 = full
seg  out  8  {dp,g,f,e,d,c,b,a} for the selected digit
seg_dig  out  4  one-hot digit strobe; bit 3 = digit 0
frame_sync  out  1  1-cycle pulse when a pending frame is committed

Behaviour:
- Reset (rst=1 at a clk edge) clears the slot counter, digit index, FSM and the pending flag, and loads the active frame with all digits blank.
  - Outputs during and after reset, until the first ON phase: seg all-off, seg_dig all-off, frame_sync=0, frame_ready=0.
  - frame_ready rises on the first cycle after rst deasserts.
- Slot counter cnt runs 0..DIV_SLOT-1 and wraps. On wrap, the digit index advances 0→1→2→3→0.
- A frame boundary is the wrap at the end of digit 3's slot.
- on_len = ((DIV_SLOT-BLANK_CYC)*(brightness+1))>>3.
  - brightness is sampled at cnt==0 and held for the slot.
  - Width must hold DIV_SLOT*8 without overflow.
- FSM states and transitions:
  - S_BLANK: entered at cnt==0. Exits to S_ON at cnt==BLANK_CYC.
  - S_ON: exits to S_OFF when cnt-BLANK_CYC == on_len. At brightness 7, on_len equals the window length, so S_ON lasts to slot end.
  - S_OFF: lasts until the wrap, then returns to S_BLANK.
- Outputs are registered, with 1-cycle latency from the state/cnt decision.
  - In S_ON, seg_dig is the strobe for the current index, and seg is the decoded nibble plus its dp.
  - If the digit's blank bit is set, seg_dig remains off for the whole slot; timing is unchanged.
  - In S_BLANK and S_OFF, both seg and seg_dig are all-off.
- Handshake:
  - frame_ready = !pending_full.
  - A transfer happens when frame_valid && frame_ready at a clk edge. frame_data/dp/blank are captured into the pending buffer and pending_full is set.
  - The producer must hold frame_* stable while valid && !ready.
- Commit: at a frame boundary with pending_full=1, active ← pending, pending_full ← 0, and frame_sync pulses in that cycle. No commit happens mid-frame.
- Transfer and boundary in the same cycle with pending empty: the data goes to pending and commits at the next boundary, not this one.
- A boundary with no pending frame keeps the active frame and produces no frame_sync.
- Reset mid-frame or mid-transfer: any pending frame is dropped and the display goes blank. The producer must re-send.

Decomposition:
- seg7_pkg holds:
  - NUM_DIGITS=4
  - FSM state enum {S_BLANK, S_ON, S_OFF}
  - 7-segment code constants for 0–F (active-high, {g..a})
  - SEG_OFF / DIG_OFF constants
- Sub-module seg7_hex_decode (combinational nibble+dp → 8-bit active-high code, using the package constants).
- Polarity inversion is applied in seg7_scan_ctrl's output registers.

Test Plan:
Bench parameters: DIV_SLOT=16, BLANK_CYC=2.
- Reset release, no frames: frame_ready=1 one cycle after rst falls; seg_dig stays all-off for 4 slots (all digits blank); frame_sync never pulses.
- Send 0x1A3C, dp=0, blank=0, brightness=7:
  - transfer completes; frame_sync pulses at the next boundary;
  - in the following frame, digit 0 shows "1", then "A", "3", "C";
  - each strobe is lit for 14 cycles after 2 blank cycles.
- brightness=3: on_len=7; the strobe is lit on cycles 2–8 of each slot and off on cycles 9–15. Change brightness mid-slot to 0: on_len=1 takes effect only from the next slot.
- Back-to-back frames:
  - frame A is accepted; frame B is held with frame_ready=0 until A commits;
  - B is accepted in the cycle after the boundary;
  - B commits at the following boundary, never mid-frame.
- blank=4'b0100 on 0x0123: digit 1 is dark for its whole slot; digits 0, 2 and 3 show 0, 2, 3; slot timing is unchanged.
- Assert rst for 1 cycle mid-S_ON with a frame pending: outputs go all-off, the pending frame is dropped, no frame_sync occurs, and scanning restarts at digit 0, cnt=0.
